// File: rtl/sec_add_ks.sv
// -----------------------------------------------------------------------------
// sec_add_ks
//   Boolean-masked modular adder (Kogge-Stone prefix network) that runs every
//   masked AND through a single shared SecAND gadget, one call at a time.
//
//   Ports:
//     clk      - clock, rising edge
//     rst_n    - asynchronous active-low reset
//     start    - request an addition; only looked at while busy=0
//     x, y     - Boolean-masked operands, share i at [i*K_WIDTH +: K_WIDTH]
//     rnd      - fresh randomness, consumed in every cycle with rnd_req=1
//     rnd_req  - high in each cycle that issues a masked AND
//     z        - Boolean-masked sum, held until the next ovld
//     busy     - high from start acceptance up to (not including) ovld
//     ovld     - one-cycle pulse marking a new z
//
//   sec_and (helper)
//     Masked AND with one cycle of latency. Each ordered share pair (i,j)
//     has its own random word; output share i gets the cross products
//     a_i&b_j plus r(i,j) and r(j,i), so every random word appears in
//     exactly two shares and cancels in the XOR of all shares.
//
//     clk, rst_n - clock / asynchronous active-low reset
//     ena        - update enable
//     dvld       - input operands valid
//     a, b       - masked operands
//     rnd        - one K_WIDTH word per ordered share pair
//     c          - masked product, valid while qvld=1
//     qvld       - output valid
// -----------------------------------------------------------------------------

module sec_and #(
  parameter int unsigned K_WIDTH  = 32,
  parameter int unsigned N_SHARES = 3
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       ena,
  input  logic                                       dvld,
  input  logic [K_WIDTH*N_SHARES-1:0]                a,
  input  logic [K_WIDTH*N_SHARES-1:0]                b,
  input  logic [K_WIDTH*N_SHARES*(N_SHARES-1)-1:0]   rnd,
  output logic [K_WIDTH*N_SHARES-1:0]                c,
  output logic                                       qvld
);

  logic [K_WIDTH*N_SHARES-1:0] c_d, c_q;
  logic                        qvld_d, qvld_q;
  logic [K_WIDTH-1:0]          acc;

  // Random word index for ordered pair (i,j), j != i.
  function automatic int unsigned pidx(input int unsigned i, input int unsigned j);
    return i * (N_SHARES - 1) + ((j < i) ? j : j - 1);
  endfunction

  always_comb begin
    c_d = '0;
    acc = '0;
    for (int unsigned i = 0; i < N_SHARES; i++) begin
      acc = a[i*K_WIDTH +: K_WIDTH] & b[i*K_WIDTH +: K_WIDTH];
      for (int unsigned j = 0; j < N_SHARES; j++) begin
        if (j != i) begin
          acc = acc
              ^ (a[i*K_WIDTH +: K_WIDTH] & b[j*K_WIDTH +: K_WIDTH])
              ^ rnd[pidx(i, j)*K_WIDTH +: K_WIDTH]
              ^ rnd[pidx(j, i)*K_WIDTH +: K_WIDTH];
        end
      end
      c_d[i*K_WIDTH +: K_WIDTH] = acc;
    end
  end

  always_comb begin
    qvld_d = qvld_q;
    if (ena) begin
      qvld_d = dvld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qvld_q <= 1'b0;
    end else begin
      qvld_q <= qvld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ena) begin
      c_q <= c_d;
    end
  end

  assign c    = c_q;
  assign qvld = qvld_q;

endmodule

module sec_add_ks #(
  parameter int unsigned K_WIDTH  = 32,
  parameter int unsigned N_SHARES = 3
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [K_WIDTH*N_SHARES-1:0]                x,
  input  logic [K_WIDTH*N_SHARES-1:0]                y,
  input  logic [K_WIDTH*N_SHARES*(N_SHARES-1)-1:0]   rnd,
  output logic                                       rnd_req,
  output logic [K_WIDTH*N_SHARES-1:0]                z,
  output logic                                       busy,
  output logic                                       ovld
);

  localparam int unsigned KN = K_WIDTH * N_SHARES;
  localparam int unsigned L  = $clog2(K_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE
  } state_t;

  // Which masked AND of the Kogge-Stone sequence is in flight.
  typedef enum logic [1:0] {
    C_INIT,
    C_G,
    C_P,
    C_FINAL
  } call_t;

  state_t          state_d, state_q;
  call_t           call_d, call_q;
  logic [2:0]      iter_d, iter_q;
  logic [L-1:0]    sh_d, sh_q;
  logic            busy_d, busy_q;
  logic            ovld_d, ovld_q;
  logic            rnd_req_d, rnd_req_q;
  logic [KN-1:0]   z_d, z_q;

  logic [KN-1:0]   x_d, x_q;
  logic [KN-1:0]   y_d, y_q;
  logic [KN-1:0]   p_d, p_q;
  logic [KN-1:0]   g_d, g_q;

  logic [KN-1:0]   and_a, and_b, and_c;
  logic            and_dvld, and_vld;

  // Share-wise logical left shift, zero fill, truncated to the share width.
  function automatic logic [KN-1:0] shl(input logic [KN-1:0] v, input logic [L-1:0] amt);
    logic [KN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_SHARES; i++) begin
      r[i*K_WIDTH +: K_WIDTH] = v[i*K_WIDTH +: K_WIDTH] << amt;
    end
    return r;
  endfunction

  // Operand select for the shared gadget. sh_q holds 2^(j-1) during
  // iteration j and 2^(L-1) by the time FINAL is issued.
  always_comb begin
    and_a = p_q;
    and_b = shl(g_q, sh_q);
    unique case (call_q)
      C_INIT:  begin and_a = x_q; and_b = y_q;            end
      C_G:     begin and_a = p_q; and_b = shl(g_q, sh_q); end
      C_P:     begin and_a = p_q; and_b = shl(p_q, sh_q); end
      C_FINAL: begin and_a = p_q; and_b = shl(g_q, sh_q); end
      default: ;
    endcase
  end

  assign and_dvld = (state_q == S_ISSUE);

  sec_and #(
    .K_WIDTH  (K_WIDTH),
    .N_SHARES (N_SHARES)
  ) u_sec_and (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (1'b1),
    .dvld (and_dvld),
    .a    (and_a),
    .b    (and_b),
    .rnd  (rnd),
    .c    (and_c),
    .qvld (and_vld)
  );

  always_comb begin
    state_d   = state_q;
    call_d    = call_q;
    iter_d    = iter_q;
    sh_d      = sh_q;
    busy_d    = busy_q;
    ovld_d    = 1'b0;
    rnd_req_d = 1'b0;
    z_d       = z_q;
    x_d       = x_q;
    y_d       = y_q;
    p_d       = p_q;
    g_d       = g_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d       = x;
          y_d       = y;
          p_d       = x ^ y;
          call_d    = C_INIT;
          iter_d    = '0;
          sh_d      = L'(1);
          busy_d    = 1'b1;
          rnd_req_d = 1'b1;
          state_d   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        if (and_vld) begin
          rnd_req_d = 1'b1;
          state_d   = S_ISSUE;
          unique case (call_q)
            C_INIT: begin
              g_d = and_c;
              if (L == 1) begin
                call_d = C_FINAL;
              end else begin
                call_d = C_G;
                iter_d = 3'd1;
              end
            end
            C_G: begin
              g_d    = g_q ^ and_c;
              call_d = C_P;
            end
            C_P: begin
              // p moves only after the g update of the same iteration.
              p_d  = and_c;
              sh_d = sh_q << 1;
              if (iter_q == 3'(L - 1)) begin
                call_d = C_FINAL;
              end else begin
                call_d = C_G;
                iter_d = iter_q + 3'd1;
              end
            end
            C_FINAL: begin
              g_d       = g_q ^ and_c;
              z_d       = x_q ^ y_q ^ shl(g_q ^ and_c, L'(1));
              ovld_d    = 1'b1;
              busy_d    = 1'b0;
              rnd_req_d = 1'b0;
              state_d   = S_IDLE;
            end
            default: ;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      call_q    <= C_INIT;
      iter_q    <= '0;
      sh_q      <= L'(1);
      busy_q    <= 1'b0;
      ovld_q    <= 1'b0;
      rnd_req_q <= 1'b0;
      z_q       <= '0;
    end else begin
      state_q   <= state_d;
      call_q    <= call_d;
      iter_q    <= iter_d;
      sh_q      <= sh_d;
      busy_q    <= busy_d;
      ovld_q    <= ovld_d;
      rnd_req_q <= rnd_req_d;
      z_q       <= z_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q <= x_d;
    y_q <= y_d;
    p_q <= p_d;
    g_q <= g_d;
  end

  assign rnd_req = rnd_req_q;
  assign z       = z_q;
  assign busy    = busy_q;
  assign ovld    = ovld_q;

endmodule

// File: tb/tb_sec_add_ks.sv
module tb_sec_add_ks;

  localparam int unsigned K   = 32;
  localparam int unsigned N   = 3;
  localparam int unsigned KN  = K * N;
  localparam int unsigned RW  = KN * (N - 1);
  localparam int unsigned LAT = 20;

  localparam int unsigned K2   = 2;
  localparam int unsigned N2   = 2;
  localparam int unsigned KN2  = K2 * N2;
  localparam int unsigned RW2  = KN2 * (N2 - 1);
  localparam int unsigned LAT2 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic            start = 1'b0;
  logic [KN-1:0]   x = '0, y = '0;
  logic [RW-1:0]   rnd;
  logic            rnd_req;
  logic [KN-1:0]   z;
  logic            busy, ovld;

  logic            start_s = 1'b0;
  logic [KN2-1:0]  x_s = '0, y_s = '0;
  logic [RW2-1:0]  rnd_s;
  logic            rnd_req_s;
  logic [KN2-1:0]  z_s;
  logic            busy_s, ovld_s;

  sec_add_ks #(.K_WIDTH(K), .N_SHARES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .rnd(rnd),
    .rnd_req(rnd_req), .z(z), .busy(busy), .ovld(ovld)
  );

  sec_add_ks #(.K_WIDTH(K2), .N_SHARES(N2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .x(x_s), .y(y_s), .rnd(rnd_s),
    .rnd_req(rnd_req_s), .z(z_s), .busy(busy_s), .ovld(ovld_s)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned ntot = 0;
  int unsigned nbad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    ntot++;
    nbad++;
    $display("FAIL %s: event not as required (cycle %0d)", name, cyc);
  endtask

  // Reference model: unmasked values and plain modular addition.
  function automatic logic [K-1:0] fold(input logic [KN-1:0] v);
    logic [K-1:0] r = '0;
    for (int i = 0; i < N; i++) r ^= v[i*K +: K];
    return r;
  endfunction

  function automatic logic [KN-1:0] mask(input logic [K-1:0] u);
    logic [KN-1:0] v;
    logic [K-1:0]  acc = u;
    for (int i = 1; i < N; i++) begin
      v[i*K +: K] = $urandom;
      acc ^= v[i*K +: K];
    end
    v[K-1:0] = acc;
    return v;
  endfunction

  function automatic logic [K2-1:0] fold_s(input logic [KN2-1:0] v);
    return v[1:0] ^ v[3:2];
  endfunction

  // Fresh randomness every cycle; zero_rnd forces an all-zero rnd bus.
  bit zero_rnd = 1'b0;
  always @(negedge clk) begin
    for (int i = 0; i < RW / 32; i++) rnd[i*32 +: 32] = zero_rnd ? 32'h0 : $urandom;
    rnd_s = RW2'($urandom_range(0, 15));
  end

  typedef struct {
    logic [K-1:0] sum;
    int unsigned  due;
    bit           rnd_on;
  } exp_t;

  typedef struct {
    logic [K2-1:0] sum;
    int unsigned   due;
  } exp_s_t;

  exp_t   sbq[$];
  exp_s_t sbq_s[$];

  int unsigned req_cnt = 0;

  always @(negedge clk) begin : mon_main
    exp_t e;
    if (!rst_n) begin
      req_cnt = 0;
    end else begin
      if (rnd_req) req_cnt++;
      if (ovld) begin
        if (sbq.size() == 0) begin
          fail_now("spurious_ovld");
        end else begin
          e = sbq.pop_front();
          chk("sum", 64'(fold(z)), 64'(e.sum));
          chk("latency", 64'(cyc), 64'(e.due));
          chk("rnd_req_cycles", 64'(req_cnt), 64'd10);
          chk("busy_at_ovld", 64'(busy), 64'd0);
          if (e.rnd_on) chk("share0_masked", 64'(z[K-1:0] != e.sum), 64'd1);
        end
        req_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin : mon_small
    exp_s_t e;
    if (rst_n && ovld_s) begin
      if (sbq_s.size() == 0) begin
        fail_now("spurious_ovld_k2");
      end else begin
        e = sbq_s.pop_front();
        chk("sum_k2", 64'(fold_s(z_s)), 64'(e.sum));
        chk("latency_k2", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Called at a falling edge; returns one falling edge after the accept edge.
  task automatic issue(input logic [K-1:0] xu, input logic [K-1:0] yu, input bit zr);
    int unsigned w = 0;
    exp_t e;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      fail_now("busy_timeout");
      return;
    end
    zero_rnd = zr;
    x = mask(xu);
    y = mask(yu);
    start = 1'b1;
    e.sum = xu + yu;
    e.due = cyc + 1 + LAT;
    e.rnd_on = !zr;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_s(input logic [K2-1:0] xu, input logic [K2-1:0] yu);
    int unsigned w = 0;
    exp_s_t e;
    logic [K2-1:0] m1, m2;
    while (busy_s && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (busy_s) begin
      fail_now("busy_timeout_k2");
      return;
    end
    m1 = K2'($urandom_range(0, 3));
    m2 = K2'($urandom_range(0, 3));
    x_s = {m1, xu ^ m1};
    y_s = {m2, yu ^ m2};
    start_s = 1'b1;
    e.sum = xu + yu;
    e.due = cyc + 1 + LAT2;
    sbq_s.push_back(e);
    @(negedge clk);
    start_s = 1'b0;
  endtask

  task automatic drain;
    int unsigned w = 0;
    while ((sbq.size() != 0 || sbq_s.size() != 0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0 || sbq_s.size() != 0) fail_now("drain_timeout");
  endtask

  logic [K-1:0] dir_x [6] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
  logic [K-1:0] dir_y [6] = '{32'h0000_0001, 32'h0000_0001, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h9ABC_DEF0};

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovld", 64'(ovld), 64'd0);
    chk("rst_rnd_req", 64'(rnd_req), 64'd0);
    chk("rst_z", 64'(z), 64'd0);
    chk("rst_busy_k2", 64'(busy_s), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases, including all-zero randomness for two of them.
    for (int i = 0; i < 6; i++) issue(dir_x[i], dir_y[i], (i == 2) || (i == 3));
    drain();

    // Start pulsed while busy is ignored; start in the ovld cycle is taken.
    issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    repeat (4) @(negedge clk);
    chk("busy_mid_op", 64'(busy), 64'd1);
    x = mask(32'h1111_1111);
    y = mask(32'h2222_2222);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    issue(32'hCAFE_0001, 32'h3501_FFFF, 1'b0);
    drain();

    // Reset in the middle of an operation.
    issue(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ovld", 64'(ovld), 64'd0);
    chk("midrst_rnd_req", 64'(rnd_req), 64'd0);
    chk("midrst_z", 64'(z), 64'd0);
    sbq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    drain();

    // Random back-to-back additions.
    for (int i = 0; i < 1500; i++) issue($urandom, $urandom, ($urandom_range(0, 7) == 0));
    drain();

    // Two-bit, two-share configuration.
    issue_s(2'd3, 2'd1);
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) issue_s(K2'(a), K2'(b));
    drain();

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
